signed_align_shifter: RTL

SIGNED_ALIGN_SHIFTER -- requirements
Module: signed_align_shifter

---
 rtl/signed_shift_pkg.sv | 33 +++
 rtl/signed_shift_stage.sv | 40 ++++
 rtl/signed_align_shifter.sv | 91 +++++++++
 3 files changed

// File: rtl/signed_shift_pkg.sv
// Shared defaults, frame-sizing helpers and the canonical pipeline stage layout
// for the signed alignment shifter.
package signed_shift_pkg;

  localparam int IN_W_DEF    = 4;
  localparam int SHIFT_W_DEF = 4;
  localparam int OUT_W_DEF   = 9;
  localparam int BIAS_DEF    = 4;

  // Bit position of the significand LSB at the most negative shift.
  function automatic int e_min(input int in_w, input int shift_w, input int bias);
    return bias - (in_w - 1) - (1 << (shift_w - 1));
  endfunction

  // Guard bits kept below output position 0 so sticky sees every shifted-out one.
  function automatic int frac_w(input int in_w, input int shift_w, input int bias);
    int lo;
    lo = e_min(in_w, shift_w, bias);
    return (lo < 0) ? -lo : 0;
  endfunction

  localparam int DATA_W_DEF = frac_w(IN_W_DEF, SHIFT_W_DEF, BIAS_DEF) + OUT_W_DEF;

  typedef struct packed {
    logic                   valid;
    logic [DATA_W_DEF-1:0]  data;
    logic [SHIFT_W_DEF-1:0] shift;
    logic                   ovf;
    logic                   sticky;
    logic                   sat;
  } stage_t;

endpackage

// File: rtl/signed_shift_stage.sv
// One registered barrel stage: conditionally shifts the frame left by 2**BIT,
// folds bits pushed off the top into ovf and re-derives sticky from the guard bits.
module signed_shift_stage
  import signed_shift_pkg::*;
#(
  parameter type stage_t = signed_shift_pkg::stage_t,
  parameter int  D_W     = DATA_W_DEF,
  parameter int  FRAC_W  = frac_w(IN_W_DEF, SHIFT_W_DEF, BIAS_DEF),
  parameter int  BIT     = 0
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   en,
  input  stage_t in_st,
  output stage_t out_st
);

  localparam int AMT = 1 << BIT;
  localparam logic [D_W-1:0] FRAC_MASK = {D_W{1'b1}} >> (D_W - FRAC_W);

  logic [D_W+AMT-1:0] wide;
  stage_t             nxt;

  // NOTE: combinational blocks assign every output a default first so no latch is inferred.
  always_comb begin
    nxt  = in_st;
    wide = {{AMT{1'b0}}, in_st.data};
    if (in_st.shift[BIT]) wide = wide << AMT;
    nxt.data   = wide[D_W-1:0];
    nxt.ovf    = in_st.ovf | (|wide[D_W+AMT-1:D_W]);
    nxt.sticky = |(wide[D_W-1:0] & FRAC_MASK);
  end

  // NOTE: state uses non-blocking assignments; data is reset too so out_data reads 0 after reset.
  always_ff @(posedge clk) begin
    if (rst)     out_st <= '0;
    else if (en) out_st <= nxt;
  end

endmodule

// File: rtl/signed_align_shifter.sv
// Pipelined signed alignment shifter: places in_sig * 2**(in_shift + BIAS - (IN_W-1))
// into an OUT_W window with overflow, sticky and optional saturation, under a global stall.
module signed_align_shifter
  import signed_shift_pkg::*;
#(
  parameter int IN_W    = IN_W_DEF,
  parameter int SHIFT_W = SHIFT_W_DEF,
  parameter int OUT_W   = OUT_W_DEF,
  parameter int BIAS    = BIAS_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [IN_W-1:0]    in_sig,
  input  logic [SHIFT_W-1:0] in_shift,
  input  logic               in_sat,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [OUT_W-1:0]   out_data,
  output logic               out_ovf,
  output logic               out_sticky
);

  // The frame starts at the most negative shift, so the biased shift only ever moves bits up:
  // anything leaving the top is overflow for good, and guard bits cover the lowest placement.
  localparam int FRAC_W = frac_w(IN_W, SHIFT_W, BIAS);
  localparam int D_W    = FRAC_W + OUT_W;
  localparam int OFF    = e_min(IN_W, SHIFT_W, BIAS) + FRAC_W;
  localparam int P_W    = D_W + IN_W + OFF;
  localparam logic [D_W-1:0]     FRAC_MASK  = {D_W{1'b1}} >> (D_W - FRAC_W);
  localparam logic [SHIFT_W-1:0] SHIFT_FLIP = {1'b1, {(SHIFT_W-1){1'b0}}};

  // Same layout as signed_shift_pkg::stage_t, sized by this instance's parameters.
  typedef struct packed {
    logic               valid;
    logic [D_W-1:0]     data;
    logic [SHIFT_W-1:0] shift;
    logic               ovf;
    logic               sticky;
    logic               sat;
  } frame_t;

  frame_t         st [SHIFT_W+1];
  frame_t         st0_nxt;
  logic [P_W-1:0] placed;
  logic           en;
  logic           unused_tail;

  assign en       = !st[SHIFT_W].valid | out_ready;
  assign in_ready = en;

  always_comb begin
    placed         = P_W'(in_sig) << OFF;
    st0_nxt.valid  = in_valid;
    st0_nxt.data   = placed[D_W-1:0];
    st0_nxt.shift  = in_shift ^ SHIFT_FLIP;
    st0_nxt.ovf    = |placed[P_W-1:D_W];
    st0_nxt.sticky = |(placed[D_W-1:0] & FRAC_MASK);
    st0_nxt.sat    = in_sat;
  end

  always_ff @(posedge clk) begin
    if (rst)     st[0] <= '0;
    else if (en) st[0] <= st0_nxt;
  end

  for (genvar k = 1; k <= SHIFT_W; k++) begin : g_stage
    signed_shift_stage #(
      .stage_t (frame_t),
      .D_W     (D_W),
      .FRAC_W  (FRAC_W),
      .BIT     (k - 1)
    ) u_stage (
      .clk    (clk),
      .rst    (rst),
      .en     (en),
      .in_st  (st[k-1]),
      .out_st (st[k])
    );
  end

  assign out_valid   = st[SHIFT_W].valid;
  assign out_ovf     = st[SHIFT_W].ovf;
  assign out_sticky  = st[SHIFT_W].sticky;
  assign out_data    = (st[SHIFT_W].ovf && st[SHIFT_W].sat) ? {OUT_W{1'b1}}
                                                            : st[SHIFT_W].data[D_W-1:FRAC_W];
  // Spent shift bits and guard bits of the last stage have no consumer.
  assign unused_tail = ^st[SHIFT_W];

endmodule
